idc_host: RTL and testbench

IDC_HOST -- requirements
Module: idc_host

---
 rtl/idc_host.sv | 181 ++++++++++++++++++
 tb/tb_idc_host.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/idc_host.sv
// Frame host for the IDC engine: it stores 64 pixels and 15 ops, streams them out,
// then collects up to 16 result beats and reports a checksum and an error code.
module idc_host #(
  parameter int TIMEOUT = 63
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [6:0]        cfg_addr,
  input  logic signed [6:0] cfg_wdata,
  input  logic              start,
  output logic              busy,
  output logic              idc_in_valid,
  output logic signed [6:0] idc_in_data,
  output logic [3:0]        idc_op,
  input  logic              idc_out_valid,
  input  logic signed [6:0] idc_out_data,
  output logic              res_valid,
  output logic [3:0]        res_idx,
  output logic signed [6:0] res_data,
  output logic              done,
  output logic [1:0]        err,
  output logic signed [10:0] checksum,
  output logic [2:0]        fsm_state
);

  // Handshakes: idc_in_valid is a push-only stream with no backpressure; one item per
  // cycle for 64 cycles. idc_out_valid beats must arrive on consecutive cycles; a gap
  // before the 16th beat ends the frame as a short burst.

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEND = 3'd1,
    WAIT = 3'd2,
    RECV = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t            state, state_n;
  logic [5:0]        k, k_n, k_inc;
  logic [15:0]       wait_cnt, wait_cnt_n;
  logic [3:0]        beat, beat_n;
  logic signed [6:0] pix [64];
  logic [3:0]        ops [15];

  logic              busy_n, in_valid_n, res_valid_n, done_n;
  logic signed [6:0] in_data_n, res_data_n;
  logic [3:0]        op_n, res_idx_n;
  logic [1:0]        err_n;
  logic signed [10:0] csum_n;

  assign fsm_state = state;
  assign k_inc     = k + 6'd1;

  // Config storage; op slots 64..78 map directly onto cfg_addr[3:0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) pix[i] <= '0;
      for (int i = 0; i < 15; i++) ops[i] <= '0;
    end else if (state == IDLE && cfg_we) begin
      if (cfg_addr < 7'd64)      pix[cfg_addr[5:0]] <= cfg_wdata;
      else if (cfg_addr < 7'd79) ops[cfg_addr[3:0]] <= cfg_wdata[3:0];
    end
  end

  always_comb begin
    state_n     = state;
    k_n         = k;
    wait_cnt_n  = wait_cnt;
    beat_n      = beat;
    in_valid_n  = 1'b0;
    in_data_n   = '0;
    op_n        = '0;
    res_valid_n = 1'b0;
    res_idx_n   = '0;
    res_data_n  = '0;
    done_n      = 1'b0;
    err_n       = err;
    csum_n      = checksum;
    case (state)
      IDLE: begin
        if (start) begin
          state_n    = SEND;
          k_n        = '0;
          err_n      = '0;
          csum_n     = '0;
          in_valid_n = 1'b1;
          // A write landing in the start cycle must already be visible to item 0.
          in_data_n  = (cfg_we && cfg_addr == 7'd0)  ? cfg_wdata      : pix[0];
          op_n       = (cfg_we && cfg_addr == 7'd64) ? cfg_wdata[3:0] : ops[0];
        end
      end
      SEND: begin
        if (k == 6'd63) begin
          state_n    = WAIT;
          wait_cnt_n = '0;
        end else begin
          k_n        = k_inc;
          in_valid_n = 1'b1;
          in_data_n  = pix[k_inc];
          op_n       = (k_inc < 6'd15) ? ops[k_inc[3:0]] : 4'd0;
        end
      end
      WAIT: begin
        if (idc_out_valid) begin
          state_n     = RECV;
          beat_n      = 4'd1;
          res_valid_n = 1'b1;
          res_idx_n   = 4'd0;
          res_data_n  = idc_out_data;
          csum_n      = checksum + 11'(idc_out_data);
        end else if (wait_cnt == WAIT_LAST) begin
          state_n = DONE;
          done_n  = 1'b1;
          err_n   = 2'd1;
        end else begin
          wait_cnt_n = wait_cnt + 16'd1;
        end
      end
      RECV: begin
        if (idc_out_valid) begin
          res_valid_n = 1'b1;
          res_idx_n   = beat;
          res_data_n  = idc_out_data;
          csum_n      = checksum + 11'(idc_out_data);
          if (beat == 4'd15) begin
            state_n = DONE;
            done_n  = 1'b1;
            err_n   = 2'd0;
          end else begin
            beat_n = beat + 4'd1;
          end
        end else begin
          state_n = DONE;
          done_n  = 1'b1;
          err_n   = 2'd2;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      k            <= '0;
      wait_cnt     <= '0;
      beat         <= '0;
      busy         <= 1'b0;
      idc_in_valid <= 1'b0;
      idc_in_data  <= '0;
      idc_op       <= '0;
      res_valid    <= 1'b0;
      res_idx      <= '0;
      res_data     <= '0;
      done         <= 1'b0;
      err          <= '0;
      checksum     <= '0;
    end else begin
      state        <= state_n;
      k            <= k_n;
      wait_cnt     <= wait_cnt_n;
      beat         <= beat_n;
      busy         <= busy_n;
      idc_in_valid <= in_valid_n;
      idc_in_data  <= in_data_n;
      idc_op       <= op_n;
      res_valid    <= res_valid_n;
      res_idx      <= res_idx_n;
      res_data     <= res_data_n;
      done         <= done_n;
      err          <= err_n;
      checksum     <= csum_n;
    end
  end

endmodule

// File: tb/tb_idc_host.sv
// Directed bench for idc_host: loads frames, plays the IDC result stream by hand
// and checks the send stream, result echo, done/err/checksum and reset behaviour.
module tb_idc_host;

  localparam int TIMEOUT = 63;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_we = 1'b0;
  logic [6:0]        cfg_addr = '0;
  logic signed [6:0] cfg_wdata = '0;
  logic              start = 1'b0;
  logic              busy;
  logic              idc_in_valid;
  logic signed [6:0] idc_in_data;
  logic [3:0]        idc_op;
  logic              idc_out_valid = 1'b0;
  logic signed [6:0] idc_out_data = '0;
  logic              res_valid;
  logic [3:0]        res_idx;
  logic signed [6:0] res_data;
  logic              done;
  logic [1:0]        err;
  logic signed [10:0] checksum;
  logic [2:0]        fsm_state;

  int n_tests = 0;
  int n_fail  = 0;
  int pix_m [64];
  int op_m  [15];

  idc_host #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .start(start), .busy(busy), .idc_in_valid(idc_in_valid), .idc_in_data(idc_in_data),
    .idc_op(idc_op), .idc_out_valid(idc_out_valid), .idc_out_data(idc_out_data),
    .res_valid(res_valid), .res_idx(res_idx), .res_data(res_data), .done(done),
    .err(err), .checksum(checksum), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input int addr, input int data);
    cfg_we    = 1'b1;
    cfg_addr  = 7'(addr);
    cfg_wdata = 7'(data);
    tick();
    cfg_we = 1'b0;
    if (addr < 64)      pix_m[addr] = data;
    else if (addr < 79) op_m[addr - 64] = data & 15;
  endtask

  // Starts a frame (optionally with a config write in the same cycle) and checks all
  // 64 send cycles; returns in the first WAIT cycle.
  task automatic send_frame(input bit with_wr, input int waddr, input int wdata);
    start = 1'b1;
    if (with_wr) begin
      cfg_we = 1'b1; cfg_addr = 7'(waddr); cfg_wdata = 7'(wdata);
      if (waddr < 64) pix_m[waddr] = wdata;
      else if (waddr < 79) op_m[waddr - 64] = wdata & 15;
    end
    tick();
    start = 1'b0;
    cfg_we = 1'b0;
    check("send_busy", int'(busy), 1);
    for (int k = 0; k < 64; k++) begin
      check($sformatf("in_valid[%0d]", k), int'(idc_in_valid), 1);
      check($sformatf("in_data[%0d]", k), int'(idc_in_data), pix_m[k]);
      check($sformatf("idc_op[%0d]", k), int'(idc_op), (k < 15) ? op_m[k] : 0);
      tick();
    end
    check("after_send_valid", int'(idc_in_valid), 0);
    check("after_send_data", int'(idc_in_data), 0);
    check("after_send_busy", int'(busy), 1);
  endtask

  task automatic beats(input int n, input int d0, input int step, output int sum);
    sum = 0;
    for (int b = 0; b < n; b++) begin
      idc_out_valid = 1'b1;
      idc_out_data  = 7'(d0 + b * step);
      tick();
      check($sformatf("res_valid[%0d]", b), int'(res_valid), 1);
      check($sformatf("res_idx[%0d]", b), int'(res_idx), b);
      check($sformatf("res_data[%0d]", b), int'(res_data), d0 + b * step);
      sum += d0 + b * step;
    end
    idc_out_valid = 1'b0;
    idc_out_data  = '0;
  endtask

  // Counts cycles since the last in_valid cycle until done, bounded.
  task automatic wait_done(output int n);
    n = 1;
    while (done !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
  endtask

  int sum;
  int n;

  initial begin
    for (int i = 0; i < 64; i++) pix_m[i] = 0;
    for (int i = 0; i < 15; i++) op_m[i] = 0;
    #12 rst = 1'b0;
    tick();
    check("rst_busy", int'(busy), 0);
    check("rst_in_valid", int'(idc_in_valid), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_checksum", int'(checksum), 0);
    check("rst_res_valid", int'(res_valid), 0);

    for (int k = 0; k < 64; k++) cfg_write(k, k - 32);

    // Result beats while idle must not be captured.
    idc_out_valid = 1'b1; idc_out_data = 7'sd9;
    tick(); tick();
    check("idle_no_capture", int'(res_valid), 0);
    check("idle_no_busy", int'(busy), 0);
    idc_out_valid = 1'b0;

    // Frame 1: ramp pixels, 16 beats of 5.
    send_frame(1'b0, 0, 0);
    tick(); tick(); tick();
    beats(16, 5, 0, sum);
    check("f1_done", int'(done), 1);
    check("f1_err", int'(err), 0);
    check("f1_checksum", int'(checksum), 80);
    tick();
    check("f1_done_pulse", int'(done), 0);
    check("f1_idle_busy", int'(busy), 0);
    check("f1_err_hold", int'(err), 0);
    check("f1_sum_hold", int'(checksum), 80);

    // Frame 2: op pattern, same-cycle write to pixel 0, then timeout.
    for (int s = 0; s < 15; s++) cfg_write(64 + s, (s < 9) ? s : s - 9);
    send_frame(1'b1, 0, 10);
    wait_done(n);
    check("timeout_latency", n, TIMEOUT + 1);
    check("timeout_err", int'(err), 1);
    check("timeout_checksum", int'(checksum), 0);
    tick();

    // Frame 3 back-to-back: short burst of 7 x -64.
    send_frame(1'b0, 0, 0);
    tick();
    beats(7, -64, 0, sum);
    tick();
    check("short_done", int'(done), 1);
    check("short_err", int'(err), 2);
    check("short_checksum", int'(checksum), -448);
    check("short_res_valid", int'(res_valid), 0);
    tick();

    // Frame 4: start during WAIT and cfg writes during RECV are ignored.
    send_frame(1'b0, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("wait_start_ignored", int'(idc_in_valid), 0);
    cfg_we = 1'b1; cfg_addr = 7'd5; cfg_wdata = 7'sd33;
    beats(16, -20, 3, sum);
    cfg_we = 1'b0;
    check("f4_done", int'(done), 1);
    check("f4_err", int'(err), 0);
    check("f4_checksum", int'(checksum), 40);
    check("f4_sum_model", sum, 40);
    tick();

    // Frame 5: stores must be unchanged.
    send_frame(1'b0, 0, 0);
    wait_done(n);
    check("f5_err", int'(err), 1);
    tick();

    // Reset in the middle of SEND.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 30; k++) tick();
    check("pre_rst_valid", int'(idc_in_valid), 1);
    check("pre_rst_data", int'(idc_in_data), pix_m[30]);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_valid", int'(idc_in_valid), 0);
    check("rst_mid_busy", int'(busy), 0);
    #1 rst = 1'b0;
    for (int i = 0; i < 64; i++) pix_m[i] = 0;
    for (int i = 0; i < 15; i++) op_m[i] = 0;
    tick();
    check("rst_no_done", int'(done), 0);
    check("rst_idle_valid", int'(idc_in_valid), 0);
    send_frame(1'b0, 0, 0);
    wait_done(n);
    check("post_rst_err", int'(err), 1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
